wired_dcache_refill: RTL and testbench
======================================

Name: wired_dcache_refill

Overview:
- Miss-handling state machine for the data cache; drives the M (line) port and T (tag) port of the 4-way cache SRAM block.
- Accepts one miss request (physical address plus victim way) and reads the victim tag.
- If the victim is valid and dirty, reads the victim line and writes it back over a word-serial bus.
- Then fetches the new 16-byte line, writes line and tag into the SRAM, and returns the line to the requester.

Parameters:
- BUS_AW, 32, bus/physical address width; tag field holds bits [BUS_AW-1:12].

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  1  miss request valid
- req_ready_o  out  1  high only in IDLE
- req_paddr_i  in  32  miss address; bits [3:0] ignored
- req_way_i  in  2  victim way chosen by requester
- done_o  out  1  one-cycle pulse: refill complete
- done_line_o  out  4x32  refilled line, word i at index i; valid with done_o
- m_way_o  out  2  SRAM M-port way
- m_addr_o  out  12  SRAM M-port address; [3:0] always 0
- m_wstrb_o  out  4x4  per-word byte strobes; all zero means read
- m_wdata_o  out  4x32  line write data
- m_rdata_i  in  4x32  line read data, one cycle after address
- t_addr_o  out  8  tag set index (paddr[11:4])
- t_we_o  out  4  one-hot tag write enable
- t_wtag_o  out  cache_tag_t  tag to write; fields v, d, addr[31:12]
- t_rtag_i  in  4x cache_tag_t  tag read data, one cycle after t_addr_o
- bus_valid_o / bus_ready_i  out/in  1/1  bus command handshake
- bus_we_o  out  1  1 = line write, 0 = line read
- bus_addr_o  out  32  line address, [3:0] = 0
- bus_wvalid_o / bus_wready_i  out/in  1/1  write-beat handshake
- bus_wdata_o  out  32  write beat data
- bus_rvalid_i  in  1  read beat valid; no backpressure
- bus_rdata_i  in  32  read beat data

Behaviour:
- Reset (async assert, sync release): state IDLE.
  - req_ready_o = 1; all other outputs 0, including done_o, t_we_o, m_wstrb_o and all bus valids.
  - Reset mid-operation aborts immediately. No SRAM write is issued after the reset edge.
- Request capture: on req_valid_i & req_ready_o, latch paddr[31:4] and way, go to TAGRD.
  - m_way_o, m_addr_o[11:4] and t_addr_o are driven from the latched values in every non-IDLE state.
- TAGRD (1 cycle, t_addr presented) -> TAGCHK.
  - TAGCHK samples t_rtag_i[way].
  - If v & d: go to LRD.
  - Otherwise: go to RCMD.
- LRD: m_wstrb = 0. Next cycle capture m_rdata_i into a 4x32 buffer, then go to WCMD.
- WCMD: bus_valid_o = 1, bus_we_o = 1, bus_addr_o = {victim.addr, set, 4'b0}.
  - Hold until bus_ready_i, then go to WDAT.
- WDAT: beats 0..3 in order; bus_wvalid_o = 1, bus_wdata_o = buffer[beat].
  - Beat counter advances on bus_wready_i.
  - After beat 3 is accepted, go to RCMD.
- RCMD: bus_valid_o = 1, bus_we_o = 0, bus_addr_o = {req addr[31:4], 4'b0}.
  - Hold until bus_ready_i, then go to RDAT.
- RDAT: each bus_rvalid_i writes bus_rdata_i into buffer[cnt] and increments a 2-bit counter.
  - After the 4th beat, go to FILL.
  - bus_rvalid_i outside RDAT is ignored.
- FILL (1 cycle), all in the same cycle:
  - m_wstrb_o = all 4'hF, m_wdata_o = buffer.
  - t_we_o = one-hot(way), t_wtag_o = {v=1, d=0, addr=req addr[31:12]}.
  - Then go to DONE.
- DONE (1 cycle): done_o = 1, done_line_o = buffer; next state IDLE.
- Outputs are registered or decoded from state and latched fields; no input-to-output combinational path except none.
- Minimum latency, clean victim, ready and data back-to-back: 1 accept + TAGRD + TAGCHK + RCMD + 4 RDAT + FILL + DONE = done_o 10 cycles after accept.
- Beat counters wrap 3 -> 0; they are reset on entry to WDAT/RDAT.
- bus_valid_o and bus_wvalid_o, once asserted, stay high with stable addr/data until their ready input is seen.

Optional Feature:
- Macro: WIRED_DCACHE_REFILL_WB_EN.
- Defined: writeback path as above.
- Undefined: LRD/WCMD/WDAT are not built. TAGCHK always goes to RCMD, the dirty bit is ignored, bus_we_o and bus_wvalid_o are tied to 0.

Test Plan:
- Clean miss: tag way2 = {v=1,d=0}, paddr 0x8000_1230, rdata beats 0x11,0x22,0x33,0x44 -> no bus write; FILL issues m_way=2, m_addr=0x230, wstrb all F, t_we=4'b0100, tag addr 0x80001; done_o with line {0x44,0x33,0x22,0x11}.
- Dirty victim (WB_EN): tag way0 = {v=1,d=1,addr=0x12345}, m_rdata = {D,C,B,A} -> bus write at 0x12345_230 with beats A,B,C,D; then read at 0x80001230; tag written with d=0.
- Backpressure: bus_ready_i low 5 cycles, bus_wready_i toggling -> valids held, addr/data stable, beat order preserved, done_o delayed accordingly.
- Sparse read beats: rvalid gaps of 0-3 cycles -> buffer order correct; exactly one FILL and one done_o.
- Reset mid-RDAT after 2 beats -> immediately IDLE, req_ready_o=1, no t_we_o/m_wstrb_o pulse; next request completes normally.
- WB_EN undefined, dirty victim -> no bus write; refill proceeds; done_o at 10 cycles.

Source files
------------

// File: rtl/wired_dcache_refill.sv
// Data-cache miss handler: victim tag check, optional dirty writeback, line fetch, SRAM fill.
// Writeback path is built only when WIRED_DCACHE_REFILL_WB_EN is defined.
module wired_dcache_refill #(
  parameter int unsigned BUS_AW = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [BUS_AW-1:0]           req_paddr_i,
  input  logic [1:0]                  req_way_i,
  output logic                        done_o,
  output logic [3:0][31:0]            done_line_o,
  output logic [1:0]                  m_way_o,
  output logic [11:0]                 m_addr_o,
  output logic [3:0][3:0]             m_wstrb_o,
  output logic [3:0][31:0]            m_wdata_o,
  input  logic [3:0][31:0]            m_rdata_i,
  output logic [7:0]                  t_addr_o,
  output logic [3:0]                  t_we_o,
  output logic [BUS_AW-11:0]          t_wtag_o,
  input  logic [3:0][BUS_AW-11:0]     t_rtag_i,
  output logic                        bus_valid_o,
  input  logic                        bus_ready_i,
  output logic                        bus_we_o,
  output logic [BUS_AW-1:0]           bus_addr_o,
  output logic                        bus_wvalid_o,
  input  logic                        bus_wready_i,
  output logic [31:0]                 bus_wdata_o,
  input  logic                        bus_rvalid_i,
  input  logic [31:0]                 bus_rdata_i
);

  localparam int unsigned TAW = BUS_AW - 12;

  typedef struct packed {
    logic           v;
    logic           d;
    logic [TAW-1:0] addr;
  } tag_t;

  typedef enum logic [3:0] {
    S_IDLE, S_TAGRD, S_TAGCHK, S_LRD, S_WCMD, S_WDAT, S_RCMD, S_RDAT, S_FILL, S_DONE
  } state_t;

  state_t              r_state, w_next;
  logic [BUS_AW-5:0]   r_line_addr;
  logic [1:0]          r_way;
  logic [3:0][31:0]    r_buf;
  logic [1:0]          r_cnt;
  logic [7:0]          w_set;
  logic                w_busy;
  tag_t                w_vtag;
  logic                w_unused;

  assign w_set  = r_line_addr[7:0];
  assign w_busy = (r_state != S_IDLE);
  assign w_vtag = t_rtag_i[r_way];

`ifdef WIRED_DCACHE_REFILL_WB_EN
  logic [TAW-1:0] r_vaddr;
  logic           r_lcap;
  assign w_unused = ^{req_paddr_i[3:0]};
`else
  assign w_unused = ^{req_paddr_i[3:0], bus_wready_i, m_rdata_i, w_vtag.d, w_vtag.addr};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_line_addr <= '0;
      r_way       <= '0;
      r_buf       <= '0;
      r_cnt       <= '0;
`ifdef WIRED_DCACHE_REFILL_WB_EN
      r_vaddr     <= '0;
      r_lcap      <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && req_valid_i) begin
        r_line_addr <= req_paddr_i[BUS_AW-1:4];
        r_way       <= req_way_i;
      end
`ifdef WIRED_DCACHE_REFILL_WB_EN
      if (r_state == S_TAGCHK) r_vaddr <= w_vtag.addr;
      // SRAM line data lands one cycle after LRD, i.e. during the first WCMD cycle
      r_lcap <= (r_state == S_LRD);
      if (r_lcap) r_buf <= m_rdata_i;
      if (r_state == S_WCMD && bus_ready_i) r_cnt <= '0;
      if (r_state == S_WDAT && bus_wready_i) r_cnt <= r_cnt + 2'd1;
`endif
      if (r_state == S_RCMD && bus_ready_i) r_cnt <= '0;
      if (r_state == S_RDAT && bus_rvalid_i) begin
        r_buf[r_cnt] <= bus_rdata_i;
        r_cnt        <= r_cnt + 2'd1;
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    req_ready_o  = (r_state == S_IDLE);
    done_o       = 1'b0;
    done_line_o  = '0;
    m_way_o      = w_busy ? r_way : 2'd0;
    m_addr_o     = w_busy ? {w_set, 4'b0000} : 12'd0;
    m_wstrb_o    = '0;
    m_wdata_o    = '0;
    t_addr_o     = w_busy ? w_set : 8'd0;
    t_we_o       = '0;
    t_wtag_o     = '0;
    bus_valid_o  = 1'b0;
    bus_we_o     = 1'b0;
    bus_addr_o   = '0;
    bus_wvalid_o = 1'b0;
    bus_wdata_o  = '0;
    case (r_state)
      S_IDLE:   if (req_valid_i) w_next = S_TAGRD;
      S_TAGRD:  w_next = S_TAGCHK;
`ifdef WIRED_DCACHE_REFILL_WB_EN
      S_TAGCHK: w_next = (w_vtag.v && w_vtag.d) ? S_LRD : S_RCMD;
      S_LRD:    w_next = S_WCMD;
      S_WCMD: begin
        bus_valid_o = 1'b1;
        bus_we_o    = 1'b1;
        bus_addr_o  = {r_vaddr, w_set, 4'b0000};
        if (bus_ready_i) w_next = S_WDAT;
      end
      S_WDAT: begin
        bus_wvalid_o = 1'b1;
        bus_wdata_o  = r_buf[r_cnt];
        if (bus_wready_i && r_cnt == 2'd3) w_next = S_RCMD;
      end
`else
      S_TAGCHK: w_next = S_RCMD;
`endif
      S_RCMD: begin
        bus_valid_o = 1'b1;
        bus_addr_o  = {r_line_addr, 4'b0000};
        if (bus_ready_i) w_next = S_RDAT;
      end
      S_RDAT:   if (bus_rvalid_i && r_cnt == 2'd3) w_next = S_FILL;
      S_FILL: begin
        m_wstrb_o = '1;
        m_wdata_o = r_buf;
        t_we_o    = 4'b0001 << r_way;
        t_wtag_o  = {1'b1, 1'b0, r_line_addr[BUS_AW-5:8]};
        w_next    = S_DONE;
      end
      S_DONE: begin
        done_o      = 1'b1;
        done_line_o = r_buf;
        w_next      = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_wired_dcache_refill.sv
// Directed bench for wired_dcache_refill: clean/dirty misses, backpressure, sparse beats, mid-refill reset.
module tb_wired_dcache_refill;
  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid_i, req_ready_o;
  logic [31:0]       req_paddr_i;
  logic [1:0]        req_way_i;
  logic              done_o;
  logic [3:0][31:0]  done_line_o;
  logic [1:0]        m_way_o;
  logic [11:0]       m_addr_o;
  logic [3:0][3:0]   m_wstrb_o;
  logic [3:0][31:0]  m_wdata_o, m_rdata_i;
  logic [7:0]        t_addr_o;
  logic [3:0]        t_we_o;
  logic [21:0]       t_wtag_o;
  logic [3:0][21:0]  t_rtag_i;
  logic              bus_valid_o, bus_ready_i, bus_we_o;
  logic [31:0]       bus_addr_o;
  logic              bus_wvalid_o, bus_wready_i;
  logic [31:0]       bus_wdata_o;
  logic              bus_rvalid_i;
  logic [31:0]       bus_rdata_i;

  always #5 clk = ~clk;

  wired_dcache_refill #(.BUS_AW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_paddr_i(req_paddr_i), .req_way_i(req_way_i),
    .done_o(done_o), .done_line_o(done_line_o),
    .m_way_o(m_way_o), .m_addr_o(m_addr_o), .m_wstrb_o(m_wstrb_o), .m_wdata_o(m_wdata_o), .m_rdata_i(m_rdata_i),
    .t_addr_o(t_addr_o), .t_we_o(t_we_o), .t_wtag_o(t_wtag_o), .t_rtag_i(t_rtag_i),
    .bus_valid_o(bus_valid_o), .bus_ready_i(bus_ready_i), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wvalid_o(bus_wvalid_o), .bus_wready_i(bus_wready_i), .bus_wdata_o(bus_wdata_o),
    .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
  );

  int checks = 0;
  int errors = 0;

  // passive monitor, sampled mid-cycle
  int               fill_cnt, wstrb_cnt, done_cnt, stab_err;
  logic [3:0]       fill_we;
  logic [11:0]      fill_maddr;
  logic [21:0]      fill_tag;
  logic [127:0]     fill_wdata;
  logic [31:0]      wbeats[$];
  logic [32:0]      cmds[$];
  logic             pend_v, pend_wv;
  logic [32:0]      pend_cmd;
  logic [31:0]      pend_wdata;

  initial begin
    fill_cnt = 0; wstrb_cnt = 0; done_cnt = 0; stab_err = 0;
    pend_v = 1'b0; pend_wv = 1'b0;
  end

  always @(negedge clk) begin
    if (t_we_o != 4'd0) begin
      fill_cnt++;
      fill_we    = t_we_o;
      fill_maddr = m_addr_o;
      fill_tag   = t_wtag_o;
      fill_wdata = m_wdata_o;
    end
    if (m_wstrb_o != 16'd0) wstrb_cnt++;
    if (done_o) done_cnt++;
    if (pend_v && (!bus_valid_o || {bus_we_o, bus_addr_o} !== pend_cmd)) stab_err++;
    if (pend_wv && (!bus_wvalid_o || bus_wdata_o !== pend_wdata)) stab_err++;
    pend_v     = bus_valid_o && !bus_ready_i;
    pend_cmd   = {bus_we_o, bus_addr_o};
    pend_wv    = bus_wvalid_o && !bus_wready_i;
    pend_wdata = bus_wdata_o;
    if (bus_valid_o && bus_ready_i) cmds.push_back({bus_we_o, bus_addr_o});
    if (bus_wvalid_o && bus_wready_i) wbeats.push_back(bus_wdata_o);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [21:0] mk_tag(input logic v, input logic d, input logic [19:0] a);
    return {v, d, a};
  endfunction

  task automatic clr();
    fill_cnt = 0; wstrb_cnt = 0; done_cnt = 0; stab_err = 0;
    fill_we = 'x; fill_maddr = 'x; fill_tag = 'x; fill_wdata = 'x;
    cmds.delete(); wbeats.delete();
  endtask

  task automatic issue(input logic [31:0] pa, input logic [1:0] way);
    req_valid_i = 1'b1; req_paddr_i = pa; req_way_i = way;
    step();
    req_valid_i = 1'b0;
  endtask

  // Zero-wait refill: bus ready during RCMD, beats back-to-back; done must land in the 10th cycle.
  task automatic run_fixed(input logic [31:0] pa, input logic [1:0] way, input logic [3:0][31:0] beats);
    bus_ready_i = 1'b1;
    issue(pa, way);
    chk("tagrd_ready", req_ready_o, 1'b0);
    chk("tagrd_taddr", t_addr_o, pa[11:4]);
    chk("tagrd_mway", m_way_o, way);
    step();
    step();
    chk("rcmd_valid", bus_valid_o, 1'b1);
    chk("rcmd_we", bus_we_o, 1'b0);
    chk("rcmd_addr", bus_addr_o, {pa[31:4], 4'h0});
    step();
    for (int i = 0; i < 4; i++) begin
      bus_rvalid_i = 1'b1; bus_rdata_i = beats[i];
      step();
    end
    bus_rvalid_i = 1'b0; bus_ready_i = 1'b0;
    chk("fill_twe", t_we_o, 4'b0001 << way);
    chk("fill_mway", m_way_o, way);
    chk("fill_maddr", m_addr_o, {pa[11:4], 4'h0});
    chk("fill_wstrb", m_wstrb_o, 16'hFFFF);
    chk("fill_wdata", m_wdata_o, beats);
    chk("fill_wtag", t_wtag_o, mk_tag(1'b1, 1'b0, pa[31:12]));
    chk("fill_done_low", done_o, 1'b0);
    step();
    chk("done_pulse", done_o, 1'b1);
    chk("done_line", done_line_o, beats);
    step();
    chk("done_one_cycle", done_o, 1'b0);
    chk("back_idle_ready", req_ready_o, 1'b1);
  endtask

  task automatic wait_cmd(input string tag);
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (bus_valid_o) begin ok = 1'b1; break; end
      step();
    end
    chk(tag, ok, 1'b1);
  endtask

  // Read command with dly cycles of backpressure (stray rvalid meanwhile), then gapped beats.
  task automatic serve_read(input logic [31:0] pa, input int dly,
                            input logic [3:0][31:0] beats, input logic [3:0][1:0] gaps);
    logic ok;
    wait_cmd("rcmd_seen");
    chk("rcmd_we_r", bus_we_o, 1'b0);
    chk("rcmd_addr_r", bus_addr_o, {pa[31:4], 4'h0});
    for (int c = 0; c < dly; c++) begin
      bus_rvalid_i = 1'b1; bus_rdata_i = 32'hDEADBEEF;
      step();
    end
    bus_rvalid_i = 1'b0;
    chk("rcmd_held", bus_valid_o, 1'b1);
    bus_ready_i = 1'b1;
    step();
    bus_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < int'(gaps[i]); g++) step();
      bus_rvalid_i = 1'b1; bus_rdata_i = beats[i];
      step();
      bus_rvalid_i = 1'b0;
    end
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (done_o) begin ok = 1'b1; break; end
      step();
    end
    chk("done_seen", ok, 1'b1);
    chk("done_line_r", done_line_o, beats);
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid_i = 1'b0; req_paddr_i = '0; req_way_i = '0;
    m_rdata_i = '0; t_rtag_i = '0;
    bus_ready_i = 1'b0; bus_wready_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
    step(); step();
    chk("rst_ready", req_ready_o, 1'b1);
    chk("rst_done", done_o, 1'b0);
    chk("rst_twe", t_we_o, 4'd0);
    chk("rst_wstrb", m_wstrb_o, 16'd0);
    chk("rst_bvalid", bus_valid_o, 1'b0);
    chk("rst_wvalid", bus_wvalid_o, 1'b0);
    rst_n = 1'b1;
    step();

    // clean miss, minimum latency
    clr();
    t_rtag_i[2] = mk_tag(1'b1, 1'b0, 20'h00ABC);
    run_fixed(32'h8000_1230, 2'd2, {32'h44, 32'h33, 32'h22, 32'h11});
    chk("clean_cmds", cmds.size(), 1);
    chk("clean_cmd0", cmds[0], {1'b0, 32'h8000_1230});
    chk("clean_nowbeats", wbeats.size(), 0);
    chk("clean_fills", fill_cnt, 1);
    chk("clean_dones", done_cnt, 1);

    // dirty victim in way 0
    clr();
    t_rtag_i[0] = mk_tag(1'b1, 1'b1, 20'h12345);
    m_rdata_i   = {32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001};
`ifdef WIRED_DCACHE_REFILL_WB_EN
    issue(32'h8000_1230, 2'd0);
    wait_cmd("wcmd_seen");
    chk("wcmd_we", bus_we_o, 1'b1);
    chk("wcmd_addr", bus_addr_o, 32'h1234_5230);
    repeat (5) step();
    chk("wcmd_held", bus_valid_o, 1'b1);
    bus_ready_i = 1'b1;
    step();
    bus_ready_i = 1'b0;
    chk("wdat_valid", bus_wvalid_o, 1'b1);
    chk("wdat_beat0", bus_wdata_o, 32'hAAAA0001);
    for (int c = 0; c < 40 && wbeats.size() < 4; c++) begin
      bus_wready_i = c[0];
      step();
    end
    bus_wready_i = 1'b0;
    chk("wb_beats", wbeats.size(), 4);
    if (wbeats.size() == 4)
      chk("wb_order", {wbeats[0], wbeats[1], wbeats[2], wbeats[3]},
          {32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 32'hDDDD0004});
    serve_read(32'h8000_1230, 2, {32'h5004, 32'h5003, 32'h5002, 32'h5001}, {2'd1, 2'd0, 2'd2, 2'd3});
    chk("dirty_cmds", cmds.size(), 2);
    chk("dirty_cmd0", cmds[0], {1'b1, 32'h1234_5230});
    chk("dirty_cmd1", cmds[1], {1'b0, 32'h8000_1230});
    chk("dirty_twe", fill_we, 4'b0001);
    chk("dirty_wtag", fill_tag, mk_tag(1'b1, 1'b0, 20'h80001));
    chk("dirty_stable", stab_err, 0);
    chk("dirty_wstrb_cnt", wstrb_cnt, 1);
`else
    run_fixed(32'h8000_1230, 2'd0, {32'h5004, 32'h5003, 32'h5002, 32'h5001});
    chk("nowb_cmds", cmds.size(), 1);
    chk("nowb_cmd0", cmds[0], {1'b0, 32'h8000_1230});
    chk("nowb_wbeats", wbeats.size(), 0);
`endif
    chk("dirty_fills", fill_cnt, 1);
    chk("dirty_dones", done_cnt, 1);

    // invalid-but-dirty victim, read backpressure, sparse beats
    clr();
    t_rtag_i[1] = mk_tag(1'b0, 1'b1, 20'h77777);
    issue(32'h4567_89AC, 2'd1);
    serve_read(32'h4567_89AC, 5, {32'h0C000004, 32'h0C000003, 32'h0C000002, 32'h0C000001},
               {2'd1, 2'd3, 2'd0, 2'd2});
    chk("sparse_cmds", cmds.size(), 1);
    chk("sparse_cmd0", cmds[0], {1'b0, 32'h4567_89A0});
    chk("sparse_wbeats", wbeats.size(), 0);
    chk("sparse_twe", fill_we, 4'b0010);
    chk("sparse_maddr", fill_maddr, 12'h9A0);
    chk("sparse_wtag", fill_tag, mk_tag(1'b1, 1'b0, 20'h45678));
    chk("sparse_wdata", fill_wdata, {32'h0C000004, 32'h0C000003, 32'h0C000002, 32'h0C000001});
    chk("sparse_stable", stab_err, 0);
    chk("sparse_fills", fill_cnt, 1);
    chk("sparse_dones", done_cnt, 1);

    // reset after two read beats
    clr();
    t_rtag_i[3] = mk_tag(1'b1, 1'b0, 20'h00001);
    bus_ready_i = 1'b1;
    issue(32'h00FF_FFF0, 2'd3);
    step(); step(); step();
    bus_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus_rvalid_i = 1'b1; bus_rdata_i = 32'h99 + i;
      step();
    end
    bus_rvalid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", req_ready_o, 1'b1);
    chk("arst_taddr", t_addr_o, 8'd0);
    chk("arst_maddr", m_addr_o, 12'd0);
    repeat (3) step();
    chk("arst_nofill", fill_cnt, 0);
    chk("arst_nowstrb", wstrb_cnt, 0);
    chk("arst_nodone", done_cnt, 0);
    rst_n = 1'b1;
    step();
    clr();
    run_fixed(32'h00FF_FFF0, 2'd3, {32'hF4, 32'hF3, 32'hF2, 32'hF1});
    chk("post_rst_fills", fill_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
